obc_da_bitserial_ctrl: RTL

//  Bit-serial driver and accumulator for the 16-point OBC distributed-arithmetic DFT bin ROM.
//  - Accepts 16 parallel signed samples.
//  - Presents one bit-slice per cycle, LSB first, on slice_out, with the sign-cycle flag m_out.
//  - Shift-accumulates the combinational ROM result rom_in into a wide sum.
//  - Returns one DFT bin term per transform through a valid/ready handshake.

---
 rtl/obc_da_bitserial_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/obc_da_bitserial_ctrl.sv
// Bit-serial driver and shift-accumulator for the 16-point OBC distributed-arithmetic
// DFT bin ROM. Presents one bit-slice of the 16 latched samples per cycle (LSB first),
// accumulates the ROM result weighted by 2^j, and returns the sum over valid/ready.
module obc_da_bitserial_ctrl #(
    parameter int DW = 16,
    parameter int RW = 32,
    parameter int AW = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*DW-1:0]  x_in,
    input  logic [RW-1:0]     obc_init,
    output logic [15:0]       slice_out,
    output logic              m_out,
    input  logic [RW-1:0]     rom_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     dft_out
);

    localparam int JW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(DW - 1);
    localparam logic [JW-1:0] J_PRE  = JW'(DW - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [JW-1:0]   j;
    logic [DW-1:0]   sh [16];
    logic [AW-1:0]   acc;
    logic [AW-1:0]   rom_ext;
    logic [AW-1:0]   acc_next;

    // Sign-extend the ROM term and weight it by 2^j for this slice.
    always_comb begin
        rom_ext  = {{(AW-RW){rom_in[RW-1]}}, rom_in};
        acc_next = acc + (rom_ext << j);
    end

    assign in_ready = (state == IDLE);

    // Transform sequencer: accept, DW slice cycles, then hold the result until taken.
    // The shift registers hold the bits still to be presented, so slice_out is
    // loaded one cycle ahead from bit 0 of each register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            acc       <= '0;
            slice_out <= '0;
            m_out     <= 1'b0;
            out_valid <= 1'b0;
            dft_out   <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                sh[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            sh[i]        <= {1'b0, x_in[i*DW+1 +: DW-1]};
                            slice_out[i] <= x_in[i*DW];
                        end
                        acc   <= {{(AW-RW){obc_init[RW-1]}}, obc_init};
                        j     <= '0;
                        m_out <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    j   <= j + 1'b1;
                    for (int unsigned i = 0; i < 16; i++) begin
                        sh[i]        <= sh[i] >> 1;
                        slice_out[i] <= sh[i][0];
                    end
                    m_out <= (j == J_PRE);
                    if (j == J_LAST) begin
                        dft_out   <= acc_next;
                        out_valid <= 1'b1;
                        slice_out <= '0;
                        m_out     <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
